// File: rtl/switch_port_mq.sv
// Multi-queue switch output port: header-addressed input FSM feeding
// NUM_CH per-channel FIFOs, drained through a strict-priority or round-robin pop arbiter.
module switch_port_mq #(
    parameter int W_WIDTH  = 8,
    parameter int DEPTH    = 16,
    parameter int NUM_CH   = 4,
    parameter int PORT_ID  = 0,
    parameter int ARB_MODE = 0,
    localparam int CH_BITS = $clog2(NUM_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_en,
    input  logic [W_WIDTH-1:0] port_addr,
    input  logic [W_WIDTH-1:0] port_data,
    input  logic               port_rd,
    output logic [W_WIDTH-1:0] port_out,
    output logic               out_valid,
    output logic [CH_BITS-1:0] out_ch,
    output logic               port_rdy,
    output logic               rd_out,
    output logic [7:0]         drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PID_W = W_WIDTH - CH_BITS;
    localparam logic [PID_W-1:0] PID = PID_W'(PORT_ID);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

    state_t state, state_nx;

    logic [CH_BITS-1:0] ch_q;
    logic [W_WIDTH-1:0] mem [NUM_CH][DEPTH];
    logic [PTR_W-1:0]   wp  [NUM_CH];
    logic [PTR_W-1:0]   rp  [NUM_CH];
    logic [CNT_W-1:0]   cnt [NUM_CH];
    logic [NUM_CH-1:0]  ne, full, wsel, psel;
    logic [CH_BITS-1:0] grant, last, idx;
    logic               hdr, wr, drop, pop;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ne[i]   = cnt[i] != '0;
            full[i] = cnt[i] == FULL_CNT;
        end
    end

    assign port_rdy = |ne;
    assign pop      = port_rd & port_rdy;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (sw_en)
                      state_nx = (port_addr[W_WIDTH-1:CH_BITS] == PID) ? WRITE : DROP;
            WRITE,
            DROP: if (!sw_en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        hdr    = 1'b0;
        wr     = 1'b0;
        drop   = 1'b0;
        rd_out = 1'b1;
        unique case (state)
            IDLE:  hdr = sw_en;
            WRITE: begin
                rd_out = ~full[ch_q];
                wr     = sw_en & ~full[ch_q];
                drop   = sw_en & full[ch_q];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)      ch_q <= '0;
        else if (hdr) ch_q <= port_addr[CH_BITS-1:0];
    end

    // Later assignments win: highest index (strict) or nearest after last (RR).
    always_comb begin
        grant = '0;
        idx   = '0;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < NUM_CH; i++)
                if (ne[i]) grant = CH_BITS'(i);
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                idx = last + CH_BITS'(k);
                if (ne[idx]) grant = idx;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wsel[i] = wr  && (ch_q  == CH_BITS'(i));
            psel[i] = pop && (grant == CH_BITS'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++)
            if (!rst && wsel[i]) mem[i][wp[i]] <= port_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wp[i]  <= '0;
                rp[i]  <= '0;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wsel[i]) wp[i] <= wp[i] + 1'b1;
                if (psel[i]) rp[i] <= rp[i] + 1'b1;
                if (wsel[i] && !psel[i])      cnt[i] <= cnt[i] + 1'b1;
                else if (psel[i] && !wsel[i]) cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            port_out  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            last      <= CH_BITS'(NUM_CH - 1);
        end else begin
            out_valid <= pop;
            if (pop) begin
                port_out <= mem[grant][rp[grant]];
                out_ch   <= grant;
                last     <= grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                         drop_cnt <= '0;
        else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end

endmodule

// File: tb/tb_switch_port_mq.sv
// Scoreboard bench: strict-priority and round-robin instances share stimulus,
// each with its own expected-output queue checked by a monitor.
module tb_switch_port_mq;

    logic       clk = 1'b0;
    logic       rst, sw_en, port_rd;
    logic [7:0] port_addr, port_data;

    logic [7:0] po0, po1, dc0, dc1;
    logic [1:0] oc0, oc1;
    logic       ov0, ov1, rdy0, rdy1, ro0, ro1;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] e0, e1;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    switch_port_mq #(.ARB_MODE(0)) u0 (
        .clk(clk), .rst(rst), .sw_en(sw_en), .port_addr(port_addr),
        .port_data(port_data), .port_rd(port_rd), .port_out(po0),
        .out_valid(ov0), .out_ch(oc0), .port_rdy(rdy0), .rd_out(ro0),
        .drop_cnt(dc0));

    switch_port_mq #(.ARB_MODE(1)) u1 (
        .clk(clk), .rst(rst), .sw_en(sw_en), .port_addr(port_addr),
        .port_data(port_data), .port_rd(port_rd), .port_out(po1),
        .out_valid(ov1), .out_ch(oc1), .port_rdy(rdy1), .rd_out(ro1),
        .drop_cnt(dc1));

    always @(negedge clk) begin
        if (!rst && ov0) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL u0_pop: got ch %0d data %h, expected no output", oc0, po0);
            end else begin
                e0 = q0.pop_front();
                if ({oc0, po0} !== e0) begin
                    n_err++;
                    $display("FAIL u0_pop: got ch %0d data %h, expected ch %0d data %h",
                             oc0, po0, e0[9:8], e0[7:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov1) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL u1_pop: got ch %0d data %h, expected no output", oc1, po1);
            end else begin
                e1 = q1.pop_front();
                if ({oc1, po1} !== e1) begin
                    n_err++;
                    $display("FAIL u1_pop: got ch %0d data %h, expected ch %0d data %h",
                             oc1, po1, e1[9:8], e1[7:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sw_en = 1'b0; port_rd = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] addr, input logic [7:0] base, input int n);
        sw_en = 1'b1; port_addr = addr;
        cyc();
        for (int i = 0; i < n; i++) begin
            port_data = base + 8'(i);
            cyc();
        end
        sw_en = 1'b0;
        cyc();
    endtask

    task automatic pop(input int n);
        port_rd = 1'b1;
        repeat (n) cyc();
        port_rd = 1'b0;
        cyc();
    endtask

    task automatic exp0(input logic [1:0] ch, input logic [7:0] d);
        q0.push_back({ch, d});
    endtask

    task automatic exp1(input logic [1:0] ch, input logic [7:0] d);
        q1.push_back({ch, d});
    endtask

    task automatic exp_both(input logic [1:0] ch, input logic [7:0] d);
        exp0(ch, d); exp1(ch, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sw_en = 1'b0; port_rd = 1'b0;
        port_addr = '0; port_data = '0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_port_out", po0, 0);
        chk("rst_out_ch", oc0, 0);
        chk("rst_out_valid", ov0, 0);
        chk("rst_port_rdy", rdy0, 0);
        chk("rst_rd_out", ro0, 1);
        chk("rst_drop_cnt", dc0, 0);
        chk("rst_rd_out_u1", ro1, 1);

        // basic packet into ch2, read back in order
        send(8'h02, 8'hA1, 3);
        exp_both(2'd2, 8'hA1); exp_both(2'd2, 8'hA2); exp_both(2'd2, 8'hA3);
        chk("basic_rdy", rdy0, 1);
        pop(3);
        #1;
        chk("basic_rdy_after", rdy0, 0);
        chk("basic_rdy_after_u1", rdy1, 0);
        chk("basic_hold_data", po0, 8'hA3);

        // packet for port 1 is discarded without counting
        send(8'h06, 8'hC0, 4);
        #1;
        chk("other_port_rdy", rdy0, 0);
        chk("other_port_drop", dc0, 0);

        // overfill ch1
        do_reset();
        sw_en = 1'b1; port_addr = 8'h01;
        cyc();
        for (int i = 0; i < 20; i++) begin
            port_data = 8'h40 + 8'(i);
            #1;
            if (i == 15) chk("full_rd_out_16th", ro0, 1);
            if (i == 16) chk("full_rd_out_17th", ro0, 0);
            cyc();
        end
        sw_en = 1'b0;
        cyc();
        chk("full_drop_cnt", dc0, 4);
        chk("full_drop_cnt_u1", dc1, 4);
        chk("full_rd_out_idle", ro0, 1);
        for (int i = 0; i < 16; i++) exp_both(2'd1, 8'h40 + 8'(i));
        pop(16);
        #1;
        chk("full_drained_rdy", rdy0, 0);

        // full ch2: same-cycle pop does not make room for the write
        do_reset();
        sw_en = 1'b1; port_addr = 8'h02;
        cyc();
        for (int i = 0; i < 16; i++) begin
            port_data = 8'h60 + 8'(i);
            cyc();
        end
        port_data = 8'h99; port_rd = 1'b1;
        exp_both(2'd2, 8'h60);
        cyc();
        sw_en = 1'b0; port_rd = 1'b0;
        cyc();
        chk("popfull_drop_cnt", dc0, 1);
        for (int i = 1; i < 16; i++) exp_both(2'd2, 8'h60 + 8'(i));
        pop(15);
        #1;
        chk("popfull_count15_rdy", rdy0, 0);

        // arbitration, one word in ch0 and ch3
        do_reset();
        send(8'h00, 8'h10, 1);
        send(8'h03, 8'h30, 1);
        exp0(2'd3, 8'h30); exp0(2'd0, 8'h10);
        exp1(2'd0, 8'h10); exp1(2'd3, 8'h30);
        pop(2);

        // arbitration, two words in every channel
        do_reset();
        for (int c = 0; c < 4; c++) send(8'(c), 8'h80 + 8'(c * 16), 2);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) exp1(2'(c), 8'h80 + 8'(c * 16 + r));
        for (int c = 3; c >= 0; c--)
            for (int r = 0; r < 2; r++) exp0(2'(c), 8'h80 + 8'(c * 16 + r));
        pop(8);

        // reset in the second payload cycle
        do_reset();
        sw_en = 1'b1; port_addr = 8'h01;
        cyc();
        port_data = 8'h51;
        cyc();
        port_data = 8'h52; rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("midrst_rdy", rdy0, 0);
        chk("midrst_drop", dc0, 0);
        port_data = 8'h53;
        cyc();
        chk("midrst_header_rdy", rdy0, 0);
        port_data = 8'h54;
        cyc();
        sw_en = 1'b0;
        #1;
        chk("midrst_payload_rdy", rdy0, 1);
        exp_both(2'd1, 8'h54);
        pop(1);

        // read while everything is empty
        port_rd = 1'b1;
        cyc();
        port_rd = 1'b0;
        #1;
        chk("empty_rd_valid", ov0, 0);
        chk("empty_rd_hold_data", po0, 8'h54);
        chk("empty_rd_hold_ch", oc0, 1);
        cyc();
        cyc();
        chk("sb_u0_left", q0.size(), 0);
        chk("sb_u1_left", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
